// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: control sequencer for the register-file/ALU datapath.
//
// Steps one decoded instruction at a time through register reads, an ALU
// or compare cycle and a writeback. Outputs are Moore (state only).
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset, forces WAIT
//   s        start strobe, sampled only in WAIT
//   opcode   instruction bits [15:13]
//   op       instruction bits [12:11]
//   w        high only in WAIT (idle, ready for s)
//   nsel     one-hot register select: 001=Rm, 010=Rd, 100=Rn
//   loada    load A register
//   loadb    load B register
//   asel     force ALU A input to 0
//   bsel     select sximm5 for ALU B input (always 0 here)
//   loadc    load C result register
//   loads    load status flags
//   vsel     writeback source: 00=C, 10=sximm8
//   write    register-file write enable
//   illegal  one-cycle pulse on an unsupported instruction
//   halted   high in HALT
//
// Parameter ILLEGAL_HALT: 0 returns to WAIT after an illegal instruction,
// 1 parks in HALT until reset.
module cpu_ctrl_fsm #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [1:0] vsel,
    output logic       write,
    output logic       illegal,
    output logic       halted
);

    typedef enum logic [3:0] {
        StWait,
        StDecode,
        StWimm,
        StGeta,
        StGetb,
        StAlu,
        StCmps,
        StWreg,
        StIll,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    // Latched {opcode, op}; decode never looks at the live inputs.
    logic [4:0] ir_q, ir_d;

    logic [2:0] opc_l;
    logic [1:0] op_l;
    assign opc_l = ir_q[4:2];
    assign op_l  = ir_q[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        w       = 1'b0;
        nsel    = 3'b000;
        loada   = 1'b0;
        loadb   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        vsel    = 2'b00;
        write   = 1'b0;
        illegal = 1'b0;
        halted  = 1'b0;

        case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) begin
                    ir_d    = {opcode, op};
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opc_l == 3'b110 && op_l == 2'b10) begin
                    state_d = StWimm;
                end else if (opc_l == 3'b110 && op_l == 2'b00) begin
                    state_d = StGetb;
                end else if (opc_l == 3'b101 && op_l == 2'b11) begin
                    // MVN has no Rn operand
                    state_d = StGetb;
                end else if (opc_l == 3'b101) begin
                    state_d = StGeta;
                end else begin
                    state_d = StIll;
                end
            end
            StWimm: begin
                nsel    = 3'b100;
                vsel    = 2'b10;
                write   = 1'b1;
                state_d = StWait;
            end
            StGeta: begin
                nsel    = 3'b100;
                loada   = 1'b1;
                state_d = StGetb;
            end
            StGetb: begin
                nsel  = 3'b001;
                loadb = 1'b1;
                if (opc_l == 3'b101 && op_l == 2'b01) begin
                    state_d = StCmps;
                end else begin
                    state_d = StAlu;
                end
            end
            StAlu: begin
                loadc   = 1'b1;
                // MOV shift passes B through, so A is zeroed
                asel    = (opc_l == 3'b110);
                state_d = StWreg;
            end
            StCmps: begin
                loads   = 1'b1;
                state_d = StWait;
            end
            StWreg: begin
                nsel    = 3'b010;
                write   = 1'b1;
                state_d = StWait;
            end
            StIll: begin
                illegal = 1'b1;
                state_d = ILLEGAL_HALT ? StHalt : StWait;
            end
            StHalt: begin
                halted  = 1'b1;
                state_d = StHalt;
            end
            default: begin
                // Unused encodings fall back to idle on the next edge.
                state_d = StWait;
            end
        endcase
    end

endmodule
